// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice.
//  - Default data/opcode widths.
//  - ALU opcode constants for the primary (R=0) and secondary R-type (R=1)
//    opcode spaces. The same numeric code means different operations in
//    the two spaces, so the R flag always travels with FUNC.
//  - Occupancy type used for the issue and result registers.
package alu_arbiter_pkg;

    localparam int DBITS_DEF      = 32;
    localparam int OPCODEBITS_DEF = 5;

    // Primary opcode space (R flag = 0)
    localparam logic [4:0] OP_ADDI = 5'h00;
    localparam logic [4:0] OP_BEQ  = 5'h04;
    localparam logic [4:0] OP_BLT  = 5'h05;

    // Secondary / R-type opcode space (R flag = 1)
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_SLT  = 5'h05;

    // Each pipeline register is either holding an operation or not.
    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way arbiter, purely combinational.
// Ports:
//  valid0, valid1  in   requests from requester 0 / 1
//  last            in   id of the most recently accepted requester
//  rr_en           in   1 = round-robin on ties, 0 = requester 0 always wins
//  gnt0, gnt1      out  grant, one-hot or all zero
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    input  logic rr_en,
    output logic gnt0,
    output logic gnt1
);

    // On a tie, round-robin hands the grant to whoever did not go last;
    // fixed priority always favours requester 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            if (rr_en && !last) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else if (valid0) begin
            gnt0 = 1'b1;
        end else if (valid1) begin
            gnt1 = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between the execute stage (requester 0) and the
// address-gen/aux unit (requester 1). A registered issue stage drives the
// ALU; a registered, tagged result stage returns the answer with
// valid/ready backpressure.
// Ports:
//  clk, rst_n                 clock (rising edge), async active-low reset
//  valid0/1, ready0/1         operand handshake per requester
//  func0/1, rflag0/1          ALU function code and opcode-space flag
//  a0/a1, b0/b1               operands
//  alu_func/alu_r/alu_a/alu_b issue register contents, to the ALU
//  alu_out, alu_z             ALU result and compare flag (combinational)
//  rvalid, rready             result handshake
//  rdata, rz, rid             registered result, flag and issuing requester
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int   DBITS      = DBITS_DEF,
    parameter int   OPCODEBITS = OPCODEBITS_DEF,
    parameter logic RR_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid0,
    input  logic                  valid1,
    output logic                  ready0,
    output logic                  ready1,
    input  logic [OPCODEBITS-1:0] func0,
    input  logic [OPCODEBITS-1:0] func1,
    input  logic                  rflag0,
    input  logic                  rflag1,
    input  logic [DBITS-1:0]      a0,
    input  logic [DBITS-1:0]      a1,
    input  logic [DBITS-1:0]      b0,
    input  logic [DBITS-1:0]      b1,
    output logic [OPCODEBITS-1:0] alu_func,
    output logic                  alu_r,
    output logic [DBITS-1:0]      alu_a,
    output logic [DBITS-1:0]      alu_b,
    input  logic [DBITS-1:0]      alu_out,
    input  logic                  alu_z,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DBITS-1:0]      rdata,
    output logic                  rz,
    output logic                  rid
);

    occ_t                  iss_state, iss_next;
    occ_t                  res_state, res_next;
    logic                  last;
    logic                  iss_id;
    logic [OPCODEBITS-1:0] iss_func;
    logic                  iss_r;
    logic [DBITS-1:0]      iss_a;
    logic [DBITS-1:0]      iss_b;
    logic                  gnt0, gnt1;
    logic                  adv, slot, accept;

    rr_arb2 u_arb (
        .valid0 (valid0),
        .valid1 (valid1),
        .last   (last),
        .rr_en  (RR_EN),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // The issue register moves forward whenever the result register is
    // empty or being drained this edge, and a new op may enter whenever the
    // issue register is empty or moving forward. This makes rready reach
    // ready0/1 combinationally, which is what allows one op per cycle.
    // ready is forced low during reset so nothing looks accepted then.
    always_comb begin
        adv    = (iss_state == OCC_FULL) && ((res_state == OCC_EMPTY) || rready);
        slot   = (iss_state == OCC_EMPTY) || adv;
        ready0 = slot && gnt0 && rst_n;
        ready1 = slot && gnt1 && rst_n;
        accept = ready0 || ready1;
    end

    // Occupancy next-state: a stage fills when something enters it and
    // empties when its content leaves without a replacement.
    always_comb begin
        iss_next = iss_state;
        res_next = res_state;
        if (accept) begin
            iss_next = OCC_FULL;
        end else if (adv) begin
            iss_next = OCC_EMPTY;
        end
        if (adv) begin
            res_next = OCC_FULL;
        end else if (rready) begin
            res_next = OCC_EMPTY;
        end
    end

    // Occupancy flags and the round-robin pointer. last starts at 1 so that
    // requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_state <= OCC_EMPTY;
            res_state <= OCC_EMPTY;
            last      <= 1'b1;
        end else begin
            iss_state <= iss_next;
            res_state <= res_next;
            if (accept) begin
                last <= gnt1;
            end
        end
    end

    // Issue register: captures the granted requester's operation. It holds
    // its value while stalled so the ALU inputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_func <= '0;
            iss_r    <= 1'b0;
            iss_a    <= '0;
            iss_b    <= '0;
            iss_id   <= 1'b0;
        end else if (accept) begin
            iss_func <= gnt1 ? func1  : func0;
            iss_r    <= gnt1 ? rflag1 : rflag0;
            iss_a    <= gnt1 ? a1     : a0;
            iss_b    <= gnt1 ? b1     : b0;
            iss_id   <= gnt1;
        end
    end

    // Result register: samples the ALU output for the op leaving the issue
    // register, tagged with the requester that issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rz    <= 1'b0;
            rid   <= 1'b0;
        end else if (adv) begin
            rdata <= alu_out;
            rz    <= alu_z;
            rid   <= iss_id;
        end
    end

    assign alu_func = iss_func;
    assign alu_r    = iss_r;
    assign alu_a    = iss_a;
    assign alu_b    = iss_b;
    assign rvalid   = (res_state == OCC_FULL);

endmodule
